proc_stream_driver: RTL
=======================

Name: proc_stream_driver

Overview:
Upstream driver for the string_process_match proc_* interface.
- Accepts a 32-bit word stream from the PS/DMA side and unpacks it into one byte per cycle on proc_data.
- Frames each batch with proc_start and proc_last.
- After proc_done, reads back the match flag, the byte position and the matched string (via proc_match_char_next), and packs them into a 32-bit response stream.

Parameters:
MAX_STR_BYTES, 55, ceiling on matched-string bytes read back (single MD5 block limit).
DRAIN_CYCLES, 66, cycles between the last emitted byte and the proc_last pulse; covers the MD5 pipeline latency.
TIMEOUT_CYCLES, 4096, watchdog limit; used only with DRIVER_TIMEOUT_EN.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_go  in  1  start a batch (honoured only in IDLE)
cfg_target_hash  in  128  target hash, latched on cmd_go
cfg_str_len  in  16  string length in bits, latched on cmd_go
s_data  in  32  input word; byte [31:24] is sent first
s_valid  in  1  input word valid
s_last  in  1  final word of the batch
s_nbytes  in  2  valid bytes in the s_last word; 0 means 4
s_ready  out  1  input word accepted when s_valid && s_ready
proc_start  out  1  one-cycle batch start pulse
proc_data  out  8  byte to string_process_match
proc_data_valid  out  1  proc_data valid
proc_last  out  1  one-cycle end-of-batch pulse
proc_target_hash  out  128  latched hash
proc_str_len  out  16  latched length
proc_match_char_next  out  1  shift matched string by one char
proc_done  in  1  batch complete
proc_match  in  1  match found
proc_byte_pos  in  32  byte index of the match
proc_match_char  in  8  current matched char
r_data  out  32  response word
r_valid  out  1  response valid
r_last  out  1  final response word
r_ready  in  1  response accept
busy  out  1  batch in progress

Behaviour:
- Reset: every output is 0 and the FSM returns to IDLE. This holds mid-operation as well: a partially emitted word is discarded, and no proc_last or response word is produced.
- FSM states: IDLE, FEED, DRAIN, WAIT_DONE, RESP_HDR, RESP_POS, RESP_CHR.
- IDLE:
  - On cmd_go: latch the hash and length, pulse proc_start for 1 cycle, set busy, go to FEED.
  - cmd_go is ignored in every other state.
- FEED, input side:
  - A word accepted at cycle N emits its bytes on cycles N+1 .. N+k, where k = 4, or s_nbytes (0 means 4) for the s_last word.
  - s_ready = buffer empty OR buffer emitting its final byte this cycle. Continuous s_valid therefore yields gap-free bytes, one per cycle.
  - s_ready is 0 outside FEED, and 0 after the s_last word is accepted.
- FEED to DRAIN: after the last byte of the s_last word is emitted.
- DRAIN:
  - Count DRAIN_CYCLES cycles; proc_last pulses on the cycle the count completes.
  - Then go to WAIT_DONE.
- WAIT_DONE: when proc_done=1, go to RESP_HDR.
- RESP_HDR:
  - r_data = {30'b0, timeout_flag, proc_match}.
  - Next state is RESP_POS.
- RESP_POS:
  - r_data = proc_byte_pos.
  - r_last=1 if proc_match=0 or the char count is 0.
- RESP_CHR:
  - Char count = min(proc_str_len[15:3], MAX_STR_BYTES).
  - Gather up to 4 chars into a word, big-endian: sample proc_match_char and pulse proc_match_char_next, one char per cycle. The next char is valid on the following cycle.
  - Unused low bytes of the final word are 0.
  - r_last is set on the final word.
  - Exactly char-count next pulses are issued per batch.
- Response handshake:
  - A word transfers on r_valid && r_ready.
  - r_data and r_last hold stable while r_valid=1 and r_ready=0.
  - No proc_match_char_next pulses are issued while a word is pending.
- After the r_last handshake: clear busy, go to IDLE.
- busy is 1 from the cmd_go cycle until the r_last handshake.

Optional Feature:
DRIVER_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_DONE. If proc_done is not seen within TIMEOUT_CYCLES, the response is word0 = 0x00000002, then word1 = 0xFFFFFFFF with r_last, and the FSM returns to IDLE.
  - The counter clears on leaving WAIT_DONE.
- Undefined: WAIT_DONE waits indefinitely and timeout_flag is constant 0.

Test Plan:
1. cmd_go, cfg_str_len=152, one word 0x41424344 with s_last, s_nbytes=0 -> proc_start pulse; proc_data 0x41,0x42,0x43,0x44 on 4 consecutive cycles; proc_last exactly 66 cycles after the 0x44 cycle.
2. 3 back-to-back words, s_nbytes=2 on the last -> 10 consecutive proc_data_valid cycles with no gaps; s_ready low after the last word.
3. proc_done=1, proc_match=0, proc_byte_pos=0x1234 -> r_data 0x00000000, then 0x00001234 with r_last; zero proc_match_char_next pulses.
4. proc_match=1, pos=7, string "ABCDEFGHIJKLMNOPQRS", str_len=152 -> words 0x1, 0x7, 0x41424344, 0x45464748, 0x494A4B4C, 0x4D4E4F50, 0x51525300 (r_last on this word); 19 next pulses.
5. In test 4, hold r_ready low 5 cycles on word 3 -> r_data stable, no extra next pulses; remaining words unchanged.
6. Assert reset mid-FEED -> all outputs 0 next cycle; a new cmd_go then runs test 1 correctly. With DRIVER_TIMEOUT_EN and proc_done never asserted -> 0x00000002, then 0xFFFFFFFF with r_last, after 4096 cycles in WAIT_DONE.

Source files
------------

// File: rtl/proc_stream_driver_if.sv
// Bus bundle between proc_stream_driver and its surroundings (PS/DMA streams,
// string_process_match proc_* port). "master" is the driver's view, "slave" the environment's.
interface proc_stream_driver_if;
    logic         cmd_go;
    logic [127:0] cfg_target_hash;
    logic [15:0]  cfg_str_len;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic [1:0]   s_nbytes;
    logic         s_ready;
    logic         proc_start;
    logic [7:0]   proc_data;
    logic         proc_data_valid;
    logic         proc_last;
    logic [127:0] proc_target_hash;
    logic [15:0]  proc_str_len;
    logic         proc_match_char_next;
    logic         proc_done;
    logic         proc_match;
    logic [31:0]  proc_byte_pos;
    logic [7:0]   proc_match_char;
    logic [31:0]  r_data;
    logic         r_valid;
    logic         r_last;
    logic         r_ready;
    logic         busy;

    modport master (
        input  cmd_go, cfg_target_hash, cfg_str_len,
        input  s_data, s_valid, s_last, s_nbytes,
        output s_ready,
        output proc_start, proc_data, proc_data_valid, proc_last,
        output proc_target_hash, proc_str_len, proc_match_char_next,
        input  proc_done, proc_match, proc_byte_pos, proc_match_char,
        output r_data, r_valid, r_last,
        input  r_ready,
        output busy
    );

    modport slave (
        output cmd_go, cfg_target_hash, cfg_str_len,
        output s_data, s_valid, s_last, s_nbytes,
        input  s_ready,
        input  proc_start, proc_data, proc_data_valid, proc_last,
        input  proc_target_hash, proc_str_len, proc_match_char_next,
        output proc_done, proc_match, proc_byte_pos, proc_match_char,
        input  r_data, r_valid, r_last,
        output r_ready,
        input  busy
    );
endinterface

// File: rtl/proc_stream_driver.sv
// Word-to-byte feeder and response packer for string_process_match.
// Optional macro DRIVER_TIMEOUT_EN enables the WAIT_DONE watchdog.
module proc_stream_driver #(
    parameter int MAX_STR_BYTES  = 55,
    parameter int DRAIN_CYCLES   = 66,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    proc_stream_driver_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FEED  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HDR   = 3'd4;
    localparam logic [2:0] S_POS   = 3'd5;
    localparam logic [2:0] S_CHR   = 3'd6;

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CHR_W   = $clog2(MAX_STR_BYTES + 1);

    logic [2:0]         r_state;
    logic [127:0]       r_hash;
    logic [15:0]        r_len;
    logic               r_start;
    logic [31:0]        r_buf;
    logic [2:0]         r_cnt;
    logic               r_got_last;
    logic [DRAIN_W-1:0] r_drain;
    logic               r_match;
    logic [31:0]        r_pos;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_valid;
    logic               r_rsp_last;
    logic [31:0]        r_acc;
    logic [CHR_W-1:0]   r_chr_rem;
    logic [1:0]         r_gcnt;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_tflag;

    logic               w_tmo_en;
    logic               w_tmo_hit;
    logic               w_idle_go;
    logic               w_s_ready;
    logic               w_s_fire;
    logic               w_emit;
    logic [2:0]         w_k;
    logic               w_drain_done;
    logic [12:0]        w_len_chars;
    logic [CHR_W-1:0]   w_nchars;
    logic               w_rsp_fire;
    logic               w_gather;
    logic [31:0]        w_acc_next;

`ifdef DRIVER_TIMEOUT_EN
    assign w_tmo_en = 1'b1;
`else
    assign w_tmo_en = 1'b0;
`endif

    assign w_idle_go    = (r_state == S_IDLE) && bus.cmd_go && !reset;
    // A word may land while the buffer is still emitting its final byte, giving gap-free output.
    assign w_s_ready    = (r_state == S_FEED) && !r_got_last && (r_cnt <= 3'd1);
    assign w_s_fire     = w_s_ready && bus.s_valid;
    assign w_emit       = (r_state == S_FEED) && (r_cnt != 3'd0);
    assign w_k          = (bus.s_last && bus.s_nbytes != 2'd0) ? {1'b0, bus.s_nbytes} : 3'd4;
    assign w_drain_done = (r_state == S_DRAIN) && (r_drain == DRAIN_W'(DRAIN_CYCLES - 1));
    assign w_len_chars  = r_len[15:3];
    assign w_nchars     = (w_len_chars > 13'(MAX_STR_BYTES)) ? CHR_W'(MAX_STR_BYTES)
                                                              : w_len_chars[CHR_W-1:0];
    assign w_rsp_fire   = r_rsp_valid && bus.r_ready;
    assign w_gather     = (r_state == S_CHR) && !r_rsp_valid;
    assign w_tmo_hit    = w_tmo_en && (r_state == S_WAIT) && !bus.proc_done &&
                          (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_acc_next = r_acc;
        case (r_gcnt)
            2'd0:    w_acc_next[31:24] = bus.proc_match_char;
            2'd1:    w_acc_next[23:16] = bus.proc_match_char;
            2'd2:    w_acc_next[15:8]  = bus.proc_match_char;
            default: w_acc_next[7:0]   = bus.proc_match_char;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !w_tmo_en || r_state != S_WAIT) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_idle_go) begin
            r_tflag <= 1'b0;
        end else if (w_tmo_hit) begin
            r_tflag <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hash      <= '0;
            r_len       <= '0;
            r_start     <= 1'b0;
            r_cnt       <= '0;
            r_got_last  <= 1'b0;
            r_drain     <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_chr_rem   <= '0;
            r_gcnt      <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_go) begin
                        r_hash     <= bus.cfg_target_hash;
                        r_len      <= bus.cfg_str_len;
                        r_start    <= 1'b1;
                        r_cnt      <= '0;
                        r_got_last <= 1'b0;
                        r_state    <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (w_s_fire) begin
                        r_buf      <= bus.s_data;
                        r_cnt      <= w_k;
                        r_got_last <= bus.s_last;
                    end else if (w_emit) begin
                        r_buf <= {r_buf[23:0], 8'h00};
                        r_cnt <= r_cnt - 3'd1;
                    end
                    if (r_got_last && r_cnt == 3'd1) begin
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_drain <= r_drain + DRAIN_W'(1);
                    end
                end
                S_WAIT: begin
                    // Result is latched so the response words stay stable under backpressure.
                    if (bus.proc_done) begin
                        r_match     <= bus.proc_match;
                        r_pos       <= bus.proc_byte_pos;
                        r_rsp_data  <= {30'b0, r_tflag, bus.proc_match};
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= 1'b0;
                        r_state     <= S_HDR;
                    end else if (w_tmo_hit) begin
                        r_rsp_data  <= 32'h0000_0002;
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= 1'b0;
                        r_state     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_rsp_fire) begin
                        r_rsp_data <= r_tflag ? 32'hFFFF_FFFF : r_pos;
                        r_rsp_last <= r_tflag || !r_match || (w_nchars == '0);
                        r_state    <= S_POS;
                    end
                end
                S_POS: begin
                    if (w_rsp_fire) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            r_rsp_last <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_chr_rem <= w_nchars;
                            r_gcnt    <= '0;
                            r_acc     <= '0;
                            r_state   <= S_CHR;
                        end
                    end
                end
                S_CHR: begin
                    if (w_gather) begin
                        r_chr_rem <= r_chr_rem - CHR_W'(1);
                        if (r_gcnt == 2'd3 || r_chr_rem == CHR_W'(1)) begin
                            r_rsp_data  <= w_acc_next;
                            r_rsp_valid <= 1'b1;
                            r_rsp_last  <= (r_chr_rem == CHR_W'(1));
                            r_gcnt      <= '0;
                            r_acc       <= '0;
                        end else begin
                            r_acc  <= w_acc_next;
                            r_gcnt <= r_gcnt + 2'd1;
                        end
                    end else if (w_rsp_fire) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            r_rsp_last <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready              = w_s_ready;
    assign bus.proc_start           = r_start;
    assign bus.proc_data            = w_emit ? r_buf[31:24] : 8'h00;
    assign bus.proc_data_valid      = w_emit;
    assign bus.proc_last            = w_drain_done;
    assign bus.proc_target_hash     = r_hash;
    assign bus.proc_str_len         = r_len;
    assign bus.proc_match_char_next = w_gather;
    assign bus.r_data               = r_rsp_data;
    assign bus.r_valid              = r_rsp_valid;
    assign bus.r_last               = r_rsp_last;
    assign bus.busy                 = (r_state != S_IDLE) || w_idle_go;
endmodule
